aurora_tx_arb: RTL and testbench

AURORA_TX_ARB -- requirements
Module: aurora_tx_arb

---
 rtl/aurora_rtds_pkg.sv | 15 +
 rtl/aurora_tx_arb.sv | 153 +++++++++++++++
 tb/tb_aurora_tx_arb.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_rtds_pkg.sv
// Shared state encodings and widths for the Aurora TX arbitration path.
package aurora_rtds_pkg;

    localparam int SEQ_W  = 32;
    localparam int DATA_W = 32;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_SEQ    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/aurora_tx_arb.sv
// Two-requester packet arbiter feeding the Aurora TX user interface, with an
// optional trailing sequence-number beat per packet.
module aurora_tx_arb
    import aurora_rtds_pkg::*;
#(
    parameter logic [SEQ_W-1:0] SEQ_INIT   = 32'h0000_0000,
    parameter bit               FIXED_PRIO = 1'b0
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,

    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tlast,

    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tlast,

    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,

    input  logic              ctrl_enable,
    input  logic              ctrl_append_seq,

    output logic [STAT_W-1:0] stat_pkts0,
    output logic [STAT_W-1:0] stat_pkts1,
    output logic [SEQ_W-1:0]  stat_seq,
    output logic              stat_busy
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              last_grant;
    logic              append_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [STAT_W-1:0] pkts0_q;
    logic [STAT_W-1:0] pkts1_q;

    logic [1:0] grant;
    logic       grant_req;
    logic       last_hs0;
    logic       last_hs1;
    logic       seq_hs;
    logic       pkt_done;

    // Returns {grant_valid, grant_index}; on a tie round-robin favours the
    // requester that was not served last.
    function automatic logic [1:0] pick_grant(input logic v0, input logic v1, input logic last_idx);
        logic [1:0] result;
        result = 2'b00;
        if (v0 && v1) begin
            result = {1'b1, (FIXED_PRIO ? 1'b0 : ~last_idx)};
        end else if (v0) begin
            result = 2'b10;
        end else if (v1) begin
            result = 2'b11;
        end
        return result;
    endfunction

    assign grant     = pick_grant(s0_axis_tvalid, s1_axis_tvalid, last_grant);
    assign grant_req = ctrl_enable & grant[1];

    assign last_hs0 = (state == ST_GRANT0) & s0_axis_tvalid & m_axis_tready & s0_axis_tlast;
    assign last_hs1 = (state == ST_GRANT1) & s1_axis_tvalid & m_axis_tready & s1_axis_tlast;
    assign seq_hs   = (state == ST_SEQ) & m_axis_tready;
    assign pkt_done = seq_hs | ((last_hs0 | last_hs1) & ~append_q);

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            append_q   <= 1'b0;
            seq_q      <= SEQ_INIT;
            pkts0_q    <= '0;
            pkts1_q    <= '0;
        end else begin
            state <= next_state;
            if ((state == ST_IDLE) && grant_req) begin
                last_grant <= grant[0];
                append_q   <= ctrl_append_seq;
            end
            if (last_hs0) begin
                pkts0_q <= pkts0_q + STAT_W'(1);
            end
            if (last_hs1) begin
                pkts1_q <= pkts1_q + STAT_W'(1);
            end
            if (pkt_done) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
        end
    end

    // Data beats pass straight through while granted; tdata/tlast are forced
    // to zero whenever tvalid is low so downstream never sees stale payload.
    always_comb begin
        next_state     = state;
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (grant_req) begin
                    next_state = grant[0] ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0: begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tdata   = s0_axis_tvalid ? s0_axis_tdata : '0;
                m_axis_tlast   = s0_axis_tvalid & s0_axis_tlast & ~append_q;
                s0_axis_tready = m_axis_tready;
                if (last_hs0) begin
                    next_state = append_q ? ST_SEQ : ST_IDLE;
                end
            end
            ST_GRANT1: begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tdata   = s1_axis_tvalid ? s1_axis_tdata : '0;
                m_axis_tlast   = s1_axis_tvalid & s1_axis_tlast & ~append_q;
                s1_axis_tready = m_axis_tready;
                if (last_hs1) begin
                    next_state = append_q ? ST_SEQ : ST_IDLE;
                end
            end
            ST_SEQ: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = seq_q;
                m_axis_tlast  = 1'b1;
                if (seq_hs) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign stat_pkts0 = pkts0_q;
    assign stat_pkts1 = pkts1_q;
    assign stat_seq   = seq_q;
    assign stat_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_aurora_tx_arb.sv
// Directed bench for aurora_tx_arb: instance 0 is round-robin with SEQ_INIT=5,
// instance 1 is fixed-priority with SEQ_INIT=FFFF_FFFF.
module tb_aurora_tx_arb;

    localparam logic        H   = 1'b1;
    localparam logic        L   = 1'b0;
    localparam logic [31:0] Z32 = 32'h0;
    localparam logic [31:0] DA  = 32'hAAAA_0001;
    localparam logic [31:0] DB  = 32'hAAAA_0002;
    localparam logic [31:0] DC  = 32'hAAAA_0003;
    localparam logic [31:0] DD  = 32'hBBBB_0004;
    localparam logic [31:0] DE  = 32'hBBBB_0005;
    localparam logic [31:0] DF  = 32'hAAAA_0006;
    localparam logic [31:0] DG  = 32'hAAAA_0007;
    localparam logic [31:0] DH  = 32'hBBBB_0008;
    localparam logic [31:0] DK  = 32'hAAAA_0009;
    localparam logic [31:0] DL  = 32'hBBBB_000A;
    localparam logic [31:0] S0D = 32'hC0C0_0001;
    localparam logic [31:0] S1D = 32'hD1D1_0001;

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        l0;
        logic        v1;
        logic [31:0] d1;
        logic        l1;
        logic        mr;
        logic        en;
        logic        app;
        logic        mv;
        logic [31:0] md;
        logic        ml;
        logic        r0;
        logic        r1;
        logic        busy;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [31:0] seq;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        s0_valid [2];
    logic        s0_ready [2];
    logic [31:0] s0_data  [2];
    logic        s0_last  [2];
    logic        s1_valid [2];
    logic        s1_ready [2];
    logic [31:0] s1_data  [2];
    logic        s1_last  [2];
    logic        m_valid  [2];
    logic        m_ready  [2];
    logic [31:0] m_data   [2];
    logic        m_last   [2];
    logic        enable   [2];
    logic        append   [2];
    logic [15:0] pkts0    [2];
    logic [15:0] pkts1    [2];
    logic [31:0] seq      [2];
    logic        busy     [2];

    int checks;
    int errors;

    aurora_tx_arb #(.SEQ_INIT(32'h0000_0005), .FIXED_PRIO(1'b0)) dut_rr (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
        .s0_axis_tvalid(s0_valid[0]), .s0_axis_tready(s0_ready[0]), .s0_axis_tdata(s0_data[0]), .s0_axis_tlast(s0_last[0]),
        .s1_axis_tvalid(s1_valid[0]), .s1_axis_tready(s1_ready[0]), .s1_axis_tdata(s1_data[0]), .s1_axis_tlast(s1_last[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]), .m_axis_tdata(m_data[0]), .m_axis_tlast(m_last[0]),
        .ctrl_enable(enable[0]), .ctrl_append_seq(append[0]),
        .stat_pkts0(pkts0[0]), .stat_pkts1(pkts1[0]), .stat_seq(seq[0]), .stat_busy(busy[0])
    );

    aurora_tx_arb #(.SEQ_INIT(32'hFFFF_FFFF), .FIXED_PRIO(1'b1)) dut_fp (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
        .s0_axis_tvalid(s0_valid[1]), .s0_axis_tready(s0_ready[1]), .s0_axis_tdata(s0_data[1]), .s0_axis_tlast(s0_last[1]),
        .s1_axis_tvalid(s1_valid[1]), .s1_axis_tready(s1_ready[1]), .s1_axis_tdata(s1_data[1]), .s1_axis_tlast(s1_last[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]), .m_axis_tdata(m_data[1]), .m_axis_tlast(m_last[1]),
        .ctrl_enable(enable[1]), .ctrl_append_seq(append[1]),
        .stat_pkts0(pkts0[1]), .stat_pkts1(pkts1[1]), .stat_seq(seq[1]), .stat_busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input int d, input logic v0, input logic [31:0] d0, input logic l0,
                                 input logic v1, input logic [31:0] d1, input logic l1,
                                 input logic mr, input logic en, input logic app);
        s0_valid[d] = v0;
        s0_data[d]  = d0;
        s0_last[d]  = l0;
        s1_valid[d] = v1;
        s1_data[d]  = d1;
        s1_last[d]  = l1;
        m_ready[d]  = mr;
        enable[d]   = en;
        append[d]   = app;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] outBundle(input int d);
        return {27'b0, m_valid[d], m_data[d], m_last[d], s0_ready[d], s1_ready[d], busy[d]};
    endfunction

    function automatic logic [63:0] statBundle(input int d);
        return {pkts0[d], pkts1[d], seq[d]};
    endfunction

    vec_t        vecs [25];
    logic [31:0] stall_src [4];
    logic [35:0] alt_exp [8];
    logic [35:0] fp_exp [6];

    initial begin
        logic [31:0] got_d [$];
        logic        got_l [$];
        int          src;
        int          cyc;
        logic        prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;

        checks = 0;
        errors = 0;

        vecs[0]  = '{H,DA,L, L,Z32,L, H,H,L, L,Z32,L,L,L,L, 16'd0,16'd0,32'd5};
        vecs[1]  = '{H,DA,L, L,Z32,L, H,H,L, H,DA,L,H,L,H,  16'd0,16'd0,32'd5};
        vecs[2]  = '{H,DB,L, L,Z32,L, H,H,L, H,DB,L,H,L,H,  16'd0,16'd0,32'd5};
        vecs[3]  = '{H,DC,H, L,Z32,L, H,H,L, H,DC,H,H,L,H,  16'd0,16'd0,32'd5};
        vecs[4]  = '{L,Z32,L, L,Z32,L, H,H,L, L,Z32,L,L,L,L, 16'd1,16'd0,32'd6};
        vecs[5]  = '{L,Z32,L, H,DD,L, H,H,H, L,Z32,L,L,L,L, 16'd1,16'd0,32'd6};
        vecs[6]  = '{L,Z32,L, H,DD,L, H,H,L, H,DD,L,L,H,H,  16'd1,16'd0,32'd6};
        vecs[7]  = '{L,Z32,L, H,DE,H, H,H,L, H,DE,L,L,H,H,  16'd1,16'd0,32'd6};
        vecs[8]  = '{L,Z32,L, L,Z32,L, H,H,L, H,32'd6,H,L,L,H, 16'd1,16'd1,32'd6};
        vecs[9]  = '{L,Z32,L, L,Z32,L, H,H,L, L,Z32,L,L,L,L, 16'd1,16'd1,32'd7};
        vecs[10] = '{H,DF,H, L,Z32,L, L,H,L, L,Z32,L,L,L,L, 16'd1,16'd1,32'd7};
        vecs[11] = '{H,DF,H, L,Z32,L, L,H,L, H,DF,H,L,L,H,  16'd1,16'd1,32'd7};
        vecs[12] = '{H,DF,H, L,Z32,L, H,H,L, H,DF,H,H,L,H,  16'd1,16'd1,32'd7};
        vecs[13] = '{H,DG,H, H,DH,H, H,H,L, L,Z32,L,L,L,L, 16'd2,16'd1,32'd8};
        vecs[14] = '{H,DG,H, H,DH,H, H,H,L, H,DH,H,L,H,H,  16'd2,16'd1,32'd8};
        vecs[15] = '{H,DG,H, H,DH,H, H,H,L, L,Z32,L,L,L,L, 16'd2,16'd2,32'd9};
        vecs[16] = '{H,DG,H, H,DH,H, H,H,L, H,DG,H,H,L,H,  16'd2,16'd2,32'd9};
        vecs[17] = '{H,DK,L, L,Z32,L, H,L,L, L,Z32,L,L,L,L, 16'd3,16'd2,32'd10};
        vecs[18] = '{H,DK,L, L,Z32,L, H,L,L, L,Z32,L,L,L,L, 16'd3,16'd2,32'd10};
        vecs[19] = '{H,DK,L, L,Z32,L, H,H,L, L,Z32,L,L,L,L, 16'd3,16'd2,32'd10};
        vecs[20] = '{L,DK,L, L,Z32,L, H,H,L, L,Z32,L,H,L,H, 16'd3,16'd2,32'd10};
        vecs[21] = '{H,DK,H, L,Z32,L, H,L,L, H,DK,H,H,L,H,  16'd3,16'd2,32'd10};
        vecs[22] = '{L,Z32,L, H,DL,H, H,L,L, L,Z32,L,L,L,L, 16'd4,16'd2,32'd11};
        vecs[23] = '{L,Z32,L, H,DL,H, H,H,L, L,Z32,L,L,L,L, 16'd4,16'd2,32'd11};
        vecs[24] = '{L,Z32,L, H,DL,H, H,H,L, H,DL,H,L,H,H,  16'd4,16'd2,32'd11};

        stall_src[0] = 32'hE000_0000;
        stall_src[1] = 32'hE000_0001;
        stall_src[2] = 32'hE000_0002;
        stall_src[3] = 32'hE000_0003;

        for (int k = 0; k < 8; k += 4) begin
            alt_exp[k]   = {H, Z32, L, L, L};
            alt_exp[k+1] = {H, S1D, H, L, H};
            alt_exp[k+2] = {L, Z32, L, L, L};
            alt_exp[k+3] = {H, S0D, H, H, L};
        end
        alt_exp[0] = {L, Z32, L, L, L};
        alt_exp[4] = {L, Z32, L, L, L};

        fp_exp[0] = {L, Z32,          L, L, L};
        fp_exp[1] = {H, S0D,          L, H, L};
        fp_exp[2] = {H, 32'hFFFF_FFFF, H, L, L};
        fp_exp[3] = {L, Z32,          L, L, L};
        fp_exp[4] = {H, S0D,          L, H, L};
        fp_exp[5] = {H, Z32,          H, L, L};

        rst_n = 1'b0;
        applyStimulus(0, L, Z32, L, L, Z32, L, L, L, L);
        applyStimulus(1, L, Z32, L, L, Z32, L, L, L, L);
        repeat (2) @(negedge clk);
        applyStimulus(0, H, DA, L, H, DB, L, H, H, L);
        #1;
        checkOutput("reset_out0", outBundle(0), 64'h0);
        checkOutput("reset_out1", outBundle(1), 64'h0);
        checkOutput("reset_stat0", statBundle(0), {16'd0, 16'd0, 32'd5});
        checkOutput("reset_stat1", statBundle(1), {16'd0, 16'd0, 32'hFFFF_FFFF});
        applyStimulus(0, L, Z32, L, L, Z32, L, L, L, L);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            applyStimulus(0, vecs[i].v0, vecs[i].d0, vecs[i].l0, vecs[i].v1, vecs[i].d1, vecs[i].l1,
                          vecs[i].mr, vecs[i].en, vecs[i].app);
            #1;
            checkOutput($sformatf("vec%0d_out", i), outBundle(0),
                        {27'b0, vecs[i].mv, vecs[i].md, vecs[i].ml, vecs[i].r0, vecs[i].r1, vecs[i].busy});
            checkOutput($sformatf("vec%0d_stat", i), statBundle(0), {vecs[i].p0, vecs[i].p1, vecs[i].seq});
        end

        $display("[TB] random backpressure on appended s0 packet");
        src = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_d = Z32;
        prev_l = 1'b0;
        while (got_d.size() < 5 && cyc < 300) begin
            @(negedge clk);
            applyStimulus(0, (src < 4), stall_src[(src < 4) ? src : 0], (src == 3), L, Z32, L,
                          1'($urandom_range(0, 1)), H, H);
            #1;
            if (prev_stall) begin
                checkOutput("stall_hold", {31'b0, m_valid[0], m_data[0], m_last[0]}, {31'b0, H, prev_d, prev_l});
            end
            prev_stall = m_valid[0] & ~m_ready[0];
            prev_d = m_data[0];
            prev_l = m_last[0];
            if (m_valid[0] && m_ready[0]) begin
                got_d.push_back(m_data[0]);
                got_l.push_back(m_last[0]);
            end
            if (s0_valid[0] && s0_ready[0]) begin
                src++;
            end
            cyc++;
        end
        checkOutput("stall_beat_count", 64'(got_d.size()), 64'd5);
        for (int k = 0; k < 5 && k < got_d.size(); k++) begin
            checkOutput($sformatf("stall_beat%0d", k), {31'b0, got_l[k], got_d[k]},
                        {31'b0, (k == 4), (k == 4) ? 32'd12 : stall_src[k]});
        end

        $display("[TB] round-robin alternation");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            applyStimulus(0, H, S0D, H, H, S1D, H, H, H, L);
            #1;
            checkOutput($sformatf("alt_cycle%0d", k),
                        {28'b0, m_valid[0], m_data[0], m_last[0], s0_ready[0], s1_ready[0]}, {28'b0, alt_exp[k]});
        end
        @(negedge clk);
        applyStimulus(0, L, Z32, L, L, Z32, L, H, H, L);
        #1;
        checkOutput("alt_stat", statBundle(0), {16'd7, 16'd5, 32'd17});

        $display("[TB] fixed priority with sequence wrap");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            applyStimulus(1, H, S0D, H, H, S1D, H, H, H, H);
            #1;
            checkOutput($sformatf("fp_cycle%0d", k),
                        {28'b0, m_valid[1], m_data[1], m_last[1], s0_ready[1], s1_ready[1]}, {28'b0, fp_exp[k]});
        end
        @(negedge clk);
        applyStimulus(1, H, S0D, H, H, S1D, H, H, H, H);
        #1;
        checkOutput("fp_stat", statBundle(1), {16'd2, 16'd0, 32'd1});

        $display("[TB] reset mid-packet");
        @(negedge clk);
        applyStimulus(1, H, S0D, H, H, S1D, H, L, H, H);
        #1;
        checkOutput("pre_reset_valid", {63'b0, m_valid[1]}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_out1", outBundle(1), 64'h0);
        checkOutput("mid_reset_stat1", statBundle(1), {16'd0, 16'd0, 32'hFFFF_FFFF});
        checkOutput("mid_reset_stat0", statBundle(0), {16'd0, 16'd0, 32'd5});
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, H, S0D, H, H, S1D, H, H, H, L);
        #1;
        checkOutput("post_reset_idle", outBundle(1), 64'h0);
        @(negedge clk);
        #1;
        checkOutput("post_reset_grant", outBundle(1), {27'b0, H, S0D, H, H, L, H});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
